// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and default parameters for the PLL reset sequencer.
package pll_reset_sequencer_pkg;

  localparam int unsigned RST_CYCLES_DEF    = 16;
  localparam int unsigned STABLE_CYCLES_DEF = 1024;
  localparam int unsigned LOCK_TIMEOUT_DEF  = 65536;
  localparam int unsigned RETRY_W           = 4;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  // Largest of three counts; sizes the shared phase counter.
  function automatic int unsigned max_of3(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared by reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-stability sequencer driving the downstream system reset.
// Optional lock timeout with retry counting is enabled by LOCK_TIMEOUT_EN.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_reset,
  output logic               running,
  output logic [RETRY_W-1:0] retries,
  output logic               timed_out
);

  localparam int unsigned CNT_MAX = max_of3(RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state;
  state_e           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             locked_s;
`ifdef LOCK_TIMEOUT_EN
  logic             timeout_c;
`endif

  sync_2ff u_sync_locked (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // State and shared phase counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PLL_RESET;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
`ifdef LOCK_TIMEOUT_EN
    timeout_c = 1'b0;
`endif
    case (state)
      PLL_RESET: begin
        if (cnt == CNT_W'(RST_CYCLES - 1)) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        // A lock seen in the timeout cycle still wins over the retry.
        if (locked_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end
`ifdef LOCK_TIMEOUT_EN
        else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_n   = PLL_RESET;
          cnt_n     = '0;
          timeout_c = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
`endif
      end
      STABLE: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s || relock_req) begin
          state_n = PLL_RESET;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = PLL_RESET;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs track the state register, updated on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      running   <= 1'b0;
    end else begin
      pll_rst   <= (state_n == PLL_RESET);
      sys_reset <= (state_n != RUN);
      running   <= (state_n == RUN);
    end
  end

`ifdef LOCK_TIMEOUT_EN
  // Timeout pulse and saturating retry count.
  always_ff @(posedge clk) begin
    if (reset) begin
      timed_out <= 1'b0;
      retries   <= '0;
    end else begin
      timed_out <= timeout_c;
      if (timeout_c && (retries != '1)) begin
        retries <= retries + RETRY_W'(1);
      end
    end
  end
`else
  assign timed_out = 1'b0;
  assign retries   = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized and directed bench for pll_reset_sequencer against a deadline-based model.
module tb_pll_reset_sequencer;

  localparam int unsigned RST = 4;
  localparam int unsigned STB = 8;
  localparam int unsigned LT  = 32;
`ifdef LOCK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_reset;
  logic       running;
  logic [3:0] retries;
  logic       timed_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RST_CYCLES    (RST),
    .STABLE_CYCLES (STB),
    .LOCK_TIMEOUT  (LT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_reset  (sys_reset),
    .running    (running),
    .retries    (retries),
    .timed_out  (timed_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: phase plus the absolute edge number at which the phase ends.
  typedef enum {M_PULSE, M_WAIT, M_STABLE, M_RUN} mph_e;
  mph_e        ph       = M_PULSE;
  int unsigned t        = 0;
  int unsigned deadline = 0;
  bit          lq[$]    = '{1'b0, 1'b0};
  int unsigned m_retries = 0;
  bit          m_to     = 1'b0;
  bit          check_en = 1'b0;

  initial forever begin
    bit ls;
    @(posedge clk);
    t++;
    if (reset) begin
      ph        = M_PULSE;
      deadline  = t + RST;
      lq        = '{1'b0, 1'b0};
      m_retries = 0;
      m_to      = 1'b0;
    end else begin
      ls   = lq.pop_front();
      lq.push_back(pll_locked);
      m_to = 1'b0;
      case (ph)
        M_PULSE:  if (t == deadline) begin ph = M_WAIT; deadline = t + LT; end
        M_WAIT: begin
          if (ls) begin
            ph = M_STABLE; deadline = t + STB;
          end else if (TO_EN && t == deadline) begin
            ph = M_PULSE; deadline = t + RST; m_to = 1'b1;
            if (m_retries < 15) m_retries++;
          end
        end
        M_STABLE: begin
          if (!ls) begin
            ph = M_WAIT; deadline = t + LT;
          end else if (t == deadline) begin
            ph = M_RUN;
          end
        end
        M_RUN: if (!ls || relock_req) begin ph = M_PULSE; deadline = t + RST; end
        default: ph = M_PULSE;
      endcase
    end
  end

  // Cycle-by-cycle scoreboard against the model.
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      check("pll_rst",   32'(pll_rst),   32'(ph == M_PULSE));
      check("sys_reset", 32'(sys_reset), 32'(ph != M_RUN));
      check("running",   32'(running),   32'(ph == M_RUN));
      check("retries",   32'(retries),   m_retries);
      check("timed_out", 32'(timed_out), 32'(m_to));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  task automatic count_pll_rst(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (pll_rst !== 1'b1) break;
      n++;
      tick(1);
    end
  endtask

  task automatic wait_sys(input string tag, input logic level, input int budget,
                          output int unsigned at);
    bit ok;
    ok = 1'b0;
    at = 0;
    for (int k = 0; k < budget; k++) begin
      if (sys_reset === level) begin
        ok = 1'b1;
        at = t;
        break;
      end
      tick(1);
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int          n;
    int unsigned t0;
    int unsigned at;
    int          entries;
    logic        prev;
    int unsigned run_left;

    reset = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    @(negedge clk);
    check_en = 1'b1;

    // Release after reset.
    do_reset(3);
    count_pll_rst(n);
    check("rst_pulse_width", n, RST);
    tick(6);
    pll_locked = 1'b1; t0 = t;
    wait_sys("release_seen", 1'b0, 40, at);
    check("release_latency", at - t0, 2 + 1 + STB);
    check("running_on_release", 32'(running), 32'd1);

    // Lock loss in RUN.
    tick(3);
    pll_locked = 1'b0; t0 = t;
    wait_sys("loss_seen", 1'b1, 10, at);
    check("loss_latency", at - t0, 3);
    count_pll_rst(n);
    check("loss_pulse_width", n, RST);
    pll_locked = 1'b1; t0 = t;
    wait_sys("relock_seen", 1'b0, 40, at);
    check("relock_latency", at - t0, 2 + 1 + STB);

    // Glitch at stability count 5.
    pll_locked = 1'b0;
    do_reset(2);
    tick(6);
    pll_locked = 1'b1; t0 = t;
    tick(6);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1; t0 = t;
    wait_sys("glitch_release_seen", 1'b0, 40, at);
    check("glitch_restart_latency", at - t0, 2 + 1 + STB);

    // relock_req in RUN.
    tick(2);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    check("req_pll_rst", 32'(pll_rst), 32'd1);
    check("req_sys_reset", 32'(sys_reset), 32'd1);
    count_pll_rst(n);
    check("req_pulse_width", n, RST);

    // relock_req in WAIT_LOCK is ignored.
    pll_locked = 1'b0;
    do_reset(2);
    tick(8);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (pll_rst === 1'b1) n++;
      tick(1);
    end
    check("wait_req_ignored", n, 0);

    // relock_req coincident with lock loss.
    pll_locked = 1'b1;
    wait_sys("coinc_run_seen", 1'b0, 40, at);
    pll_locked = 1'b0; t0 = t;
    tick(2);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    entries = 0; n = 0; prev = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (pll_rst === 1'b1 && !prev) entries++;
      if (pll_rst === 1'b1) n++;
      prev = pll_rst;
      tick(1);
    end
    check("coinc_entries", entries, 1);
    check("coinc_pulse_width", n, RST);

`ifdef LOCK_TIMEOUT_EN
    // Repeated lock timeouts with retry saturation.
    pll_locked = 1'b0;
    do_reset(3);
    t0 = t;
    for (int k = 1; k <= 17; k++) begin
      bit seen;
      seen = 1'b0;
      for (int b = 0; b < 50; b++) begin
        if (timed_out === 1'b1) begin seen = 1'b1; break; end
        tick(1);
      end
      check($sformatf("to_seen_%0d", k), 32'(seen), 32'd1);
      check($sformatf("to_period_%0d", k), t - t0, RST + LT);
      check($sformatf("to_retries_%0d", k), 32'(retries), (k < 15) ? k : 15);
      t0 = t;
      tick(1);
      check($sformatf("to_width_%0d", k), 32'(timed_out), 32'd0);
    end
    do_reset(1);
    check("retries_cleared", 32'(retries), 32'd0);
`else
    // No timeout: WAIT_LOCK holds indefinitely.
    pll_locked = 1'b0;
    do_reset(3);
    count_pll_rst(n);
    check("nto_initial_pulse", n, RST);
    begin
      int any_rst, any_to, any_ret;
      any_rst = 0; any_to = 0; any_ret = 0;
      for (int k = 0; k < 1000; k++) begin
        if (pll_rst !== 1'b0) any_rst++;
        if (timed_out !== 1'b0) any_to++;
        if (retries !== 4'd0) any_ret++;
        tick(1);
      end
      check("nto_pll_rst_quiet", any_rst, 0);
      check("nto_timed_out_quiet", any_to, 0);
      check("nto_retries_quiet", any_ret, 0);
    end
`endif

    // Randomized traffic; the scoreboard checks every cycle.
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run_left == 0) begin
        pll_locked = ~pll_locked;
        if (pll_locked) run_left = $urandom_range(1, 40);
        else if ($urandom_range(0, 7) == 0) run_left = $urandom_range(30, 80);
        else run_left = $urandom_range(1, 10);
      end
      run_left--;
      relock_req = ($urandom_range(0, 24) == 0);
      reset      = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    relock_req = 1'b0;
    reset      = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: pll_rst pulse width in clk cycles, at least 1.
REQ-002 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before release, at least 1.
REQ-003 Parameter LOCK_TIMEOUT, default 65536: maximum WAIT_LOCK cycles before a retry, at least 1; used only with the REQ-023 macro defined.
REQ-004 clk  input  1  free-running PLL reference clock (50 MHz); the block's only clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pll_locked  input  1  PLL lock indicator, asynchronous to clk.
REQ-007 relock_req  input  1  single-cycle request to force a PLL relock.
REQ-008 pll_rst  output  1  PLL reset, active-high.
REQ-009 sys_reset  output  1  downstream system reset, active-high.
REQ-010 running  output  1  high only in RUN.
REQ-011 retries  output  4  saturating count of lock timeouts since reset.
REQ-012 timed_out  output  1  one-cycle pulse on each lock timeout.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer; locked_s is its output, so locked_s lags pll_locked by 2 cycles.
REQ-014 The FSM SHALL have states PLL_RESET, WAIT_LOCK, STABLE and RUN, with one shared down/up counter sized for the largest parameter.
REQ-015 PLL_RESET: pll_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
REQ-016 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE with the counter cleared.
REQ-017 STABLE: count consecutive cycles with locked_s=1; locked_s=0 -> WAIT_LOCK with the counter cleared; count reaching STABLE_CYCLES -> RUN.
REQ-018 RUN: locked_s=0 -> PLL_RESET; relock_req=1 -> PLL_RESET; if both occur in the same cycle, take a single transition.
REQ-019 relock_req SHALL be ignored in every state except RUN.
REQ-020 All outputs SHALL be registered and decoded from the state register:
- sys_reset=1 in every state except RUN.
- running=1 only in RUN.
- pll_rst=1 only in PLL_RESET.
- On leaving RUN, sys_reset rises on the same edge that the state changes.
REQ-021 retries SHALL saturate at 15 and never wrap.
REQ-022 Latency from pll_locked rising (with the FSM in WAIT_LOCK) to sys_reset falling SHALL be 2 + 1 + STABLE_CYCLES cycles: 2 synchronizer cycles, 1 cycle to enter STABLE, then the stability count.

Configuration
REQ-023 With LOCK_TIMEOUT_EN defined, WAIT_LOCK reaching LOCK_TIMEOUT cycles SHALL:
- go to PLL_RESET;
- pulse timed_out for one cycle;
- increment retries (saturating).
If locked_s=1 in the timeout cycle, locked_s wins and the FSM goes to STABLE.
REQ-024 With LOCK_TIMEOUT_EN undefined:
- WAIT_LOCK waits indefinitely;
- timed_out and retries are tied to 0;
- LOCK_TIMEOUT is unused.

Reset
REQ-025 reset=1 SHALL, on the next clk edge and from any state:
- set the state to PLL_RESET with the counter cleared;
- set pll_rst=1, sys_reset=1, running=0, retries=0, timed_out=0;
- clear both synchronizer flops.
REQ-026 reset asserted mid-sequence SHALL restart a full RST_CYCLES pll_rst pulse after reset deasserts.

Structure
REQ-027 Package pll_reset_sequencer_pkg SHALL hold the state enum typedef and the default-parameter constants.
REQ-028 The 2-flop synchronizer SHALL be the sub-module sync_2ff (1-bit, clk and reset ports), instantiated once.

Verification
All scenarios use RST_CYCLES=4, STABLE_CYCLES=8 and LOCK_TIMEOUT=32.
REQ-029 Release after reset: hold reset 3 cycles; raise pll_locked 10 cycles later and hold it.
- Required: pll_rst is high for exactly 4 cycles after reset deasserts.
- Required: sys_reset falls exactly 11 cycles after pll_locked rises.
- Required: running rises on the same edge.
REQ-030 Glitch in STABLE: drop pll_locked for 1 cycle at stability count 5.
- Required: the FSM returns to WAIT_LOCK.
- Required: sys_reset stays 1.
- Required: the full 8-cycle stability count restarts after relock.
REQ-031 Lock loss in RUN: drop pll_locked.
- Required: sys_reset rises 3 cycles later.
- Required: pll_rst is then high for 4 cycles.
- Required: on relock, running returns after the REQ-022 latency.
REQ-032 relock_req:
- Pulse in RUN: pll_rst=1 on the next cycle and sys_reset=1.
- Pulse in WAIT_LOCK: no effect.
- Pulse in the same cycle as lock loss: exactly one PLL_RESET entry.
REQ-033 Timeout (LOCK_TIMEOUT_EN defined): keep pll_locked=0.
- Required: timed_out pulses every 4+32 cycles.
- Required: retries counts 1, 2, … and holds at 15 after 16 timeouts.
- Required: reset clears retries to 0.
REQ-034 Timeout (LOCK_TIMEOUT_EN undefined): keep pll_locked=0 for 1000 cycles.
- Required: pll_rst stays 0 after the initial 4-cycle pulse.
- Required: timed_out and retries stay 0.
